// File: rtl/shifter_display_scanner.sv
// shifter_display_scanner: scans four hex digits out to a segment and a digit-select shift register pair.
module shifter_display_scanner #(
    parameter int SHIFT_DIV    = 4,
    parameter int DWELL_CYCLES = 25_000,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wr_valid,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    output logic        o_wr_ready,
    output logic        o_shifter_a_ds,
    output logic        o_shifter_b_ds,
    output logic        o_shifter_cp,
    output logic        o_shifter_mr_n,
    output logic        o_frame_done
);
    typedef enum logic [2:0] {CLEAR, LOAD, SHIFT_LO, SHIFT_HI, DWELL} state_t;

    localparam int MAXA = (SHIFT_DIV > DWELL_CYCLES) ? SHIFT_DIV : DWELL_CYCLES;
    localparam int MAXP = (MAXA > CLEAR_CYCLES) ? MAXA : CLEAR_CYCLES;
    localparam int CW   = $clog2(MAXP + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [15:0]   pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
    logic [3:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic          shift_end, dwell_end, clear_end, shifting, boundary;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            4'hF: seg7 = 7'h71;
        endcase
    endfunction

    assign shift_end      = cnt_q == CW'(SHIFT_DIV - 1);
    assign dwell_end      = cnt_q == CW'(DWELL_CYCLES - 1);
    assign clear_end      = (state_q == CLEAR) && (cnt_q == CW'(CLEAR_CYCLES - 1));
    assign shifting       = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
    assign o_shifter_mr_n = state_q != CLEAR;
    assign o_wr_ready     = state_q != CLEAR;
    assign o_shifter_cp   = state_q == SHIFT_HI;
    assign o_shifter_a_ds = shifting & a_q[bit_q];
    assign o_shifter_b_ds = shifting & b_q[bit_q];
    assign o_frame_done   = (state_q == DWELL) && dwell_end && (idx_q == 2'd3);
    assign boundary       = o_frame_done | clear_end;

    // Next-state sequencing; pending buffer bypasses straight into the display buffer on a frame boundary
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        bit_d      = bit_q;
        a_d        = a_q;
        b_d        = b_q;
        pend_dig_d = (i_wr_valid && o_wr_ready) ? i_digits : pend_dig_q;
        pend_dp_d  = (i_wr_valid && o_wr_ready) ? i_dp : pend_dp_q;
        disp_dig_d = boundary ? pend_dig_d : disp_dig_q;
        disp_dp_d  = boundary ? pend_dp_d : disp_dp_q;
        case (state_q)
            CLEAR: if (clear_end) begin
                state_d = LOAD;
                cnt_d   = '0;
                idx_d   = 2'd0;
            end
            LOAD: begin
                state_d = SHIFT_LO;
                cnt_d   = '0;
                a_d     = {disp_dp_q[idx_q], seg7(disp_dig_q[{idx_q, 2'b00} +: 4])};
                b_d     = 8'd1 << idx_q;
                bit_d   = 3'd7;
            end
            SHIFT_LO: if (shift_end) begin
                state_d = SHIFT_HI;
                cnt_d   = '0;
            end
            SHIFT_HI: if (shift_end) begin
                state_d = (bit_q == 3'd0) ? DWELL : SHIFT_LO;
                bit_d   = (bit_q == 3'd0) ? bit_q : bit_q - 3'd1;
                cnt_d   = '0;
            end
            DWELL: if (dwell_end) begin
                state_d = LOAD;
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and buffer registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            idx_q      <= '0;
            bit_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bit_q      <= bit_d;
            a_q        <= a_d;
            b_q        <= b_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
        end
    end
endmodule
